// File: rtl/regfile_sweeper.sv
// regfile_sweeper: sequential master that dumps a register file over a valid/ready
// stream or clears it to zero, one register per cycle. Checksum: REGFILE_SWEEP_CHECKSUM_EN.
module regfile_sweeper #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_read_addr,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic              rf_write_en,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DUMP  = 2'd1,
        DRAIN = 2'd2,
        CLEAR = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(NUM_REGS - 1);
    localparam logic [ADDR_W:0] IDX_ONE  = (ADDR_W+1)'(1);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;

    logic handshake;
    logic at_last;
    logic dump_start;

    assign handshake  = out_valid_q & out_ready;
    assign at_last    = (idx_q == LAST_IDX);
    assign dump_start = (state_q == IDLE) & start & ~mode;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        done_d      = 1'b0;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    state_d = mode ? CLEAR : DUMP;
                end
            end
            DUMP: begin
                // Load whenever the holding register is empty or being consumed,
                // which gives back-to-back words with no bubble.
                if (!out_valid_q || out_ready) begin
                    out_data_d  = rf_read_data;
                    out_addr_d  = idx_q[ADDR_W-1:0];
                    out_valid_d = 1'b1;
                    out_last_d  = at_last;
                    idx_d       = idx_q + IDX_ONE;
                    if (at_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (handshake) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end
            end
            CLEAR: begin
                idx_d = idx_q + IDX_ONE;
                if (at_last) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign out_data      = out_data_q;
    assign out_addr      = out_addr_q;
    assign out_valid     = out_valid_q;
    assign out_last      = out_last_q;
    assign rf_read_addr  = (state_q == DUMP)  ? idx_q[ADDR_W-1:0] : '0;
    assign rf_write_en   = (state_q == CLEAR);
    assign rf_write_addr = (state_q == CLEAR) ? idx_q[ADDR_W-1:0] : '0;
    assign rf_write_data = '0;

`ifdef REGFILE_SWEEP_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q, checksum_d;

    // Cleared on dump start, folds in each consumed word; clears leave it alone.
    always_comb begin
        checksum_d = checksum_q;
        if (dump_start) begin
            checksum_d = '0;
        end else if (handshake) begin
            checksum_d = checksum_q ^ out_data_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    logic unused_dump_start;
    assign unused_dump_start = dump_start;
    assign checksum          = '0;
`endif

endmodule

// File: tb/tb_regfile_sweeper.sv
// Directed bench for regfile_sweeper with a behavioural register file model.
module tb_regfile_sweeper;
    localparam int DW = 64;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clock = 1'b0;
    logic          reset, start, mode, out_ready;
    logic          busy, done, rf_write_en, out_valid, out_last;
    logic [AW-1:0] rf_read_addr, rf_write_addr, out_addr;
    logic [DW-1:0] rf_read_data, rf_write_data, out_data, checksum;

    logic [DW-1:0] rf [NR];
    logic          load_req;
    int            pat_sel;
    int            checks = 0;
    int            errors = 0;

    regfile_sweeper #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
        .clock(clock), .reset(reset), .start(start), .mode(mode),
        .busy(busy), .done(done),
        .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
        .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
        .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready), .checksum(checksum)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] pat(int sel, int i);
        case (sel)
            0:       return 64'h1000 + DW'(i);
            1:       return DW'(i);
            2:       return (i == 5) ? 64'hFF : 64'h0;
            default: return 64'hA5A5_0000_0000_0000 + DW'(i * 3);
        endcase
    endfunction

    always @(posedge clock) begin
        if (load_req) begin
            for (int i = 0; i < NR; i++) rf[i] <= pat(pat_sel, i);
        end else if (rf_write_en) begin
            rf[rf_write_addr] <= rf_write_data;
        end
    end

    assign rf_read_data = rf[rf_read_addr];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input int sel);
        pat_sel  = sel;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    // Issues one command with out_ready high; cyc = ticks from start to done, -1 on timeout.
    task automatic run_cmd(input logic m, output int cyc);
        out_ready = 1'b1;
        start     = 1'b1;
        mode      = m;
        cyc       = -1;
        for (int c = 1; c <= 100; c++) begin
            tick();
            start = 1'b0;
            if (done) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; mode = 1'b0; out_ready = 1'b0; load_req = 1'b0; pat_sel = 0;
        tick(); tick();
        checks++;
        if ({busy, done, out_valid, out_last, rf_write_en} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 00000", {busy, done, out_valid, out_last, rf_write_en});
        end
        reset = 1'b0;
        tick();
        checks++;
        if (out_data !== '0 || out_addr !== '0 || rf_read_addr !== '0 || checksum !== '0) begin
            errors++; $display("FAIL reset_values: data %h addr %0d raddr %0d sum %h want all 0", out_data, out_addr, rf_read_addr, checksum);
        end
        checks++;
        if ({busy, done, out_valid} !== 3'b0) begin
            errors++; $display("FAIL idle_after_reset: got %b want 000", {busy, done, out_valid});
        end
    endtask

    task automatic test_dump_full();
        preload(0);
        out_ready = 1'b1; start = 1'b1; mode = 1'b0;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL dump_n1: busy %b valid %b want 1 0", busy, out_valid);
        end
        for (int k = 0; k < NR; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_addr !== AW'(k) || out_data !== 64'h1000 + DW'(k) ||
                out_last !== (k == NR - 1) || done !== 1'b0) begin
                errors++;
                $display("FAIL dump_beat %0d: valid %b addr %0d data %h last %b want 1 %0d %h %b",
                         k, out_valid, out_addr, out_data, out_last, k, 64'h1000 + DW'(k), k == NR - 1);
            end
        end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL dump_done_n34: done %b busy %b valid %b want 1 0 0", done, busy, out_valid);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL done_one_cycle: got %b want 0", done);
        end
    endtask

    task automatic test_dump_stall();
        int            exp_idx;
        logic          pv, pr, got_done;
        logic [DW-1:0] pd, exp_sum;
        logic [AW-1:0] pa;
        preload(3);
        out_ready = 1'b1; start = 1'b1; mode = 1'b0;
        tick();
        start = 1'b0;
        exp_idx = 0; pv = 1'b0; pr = 1'b0; pd = '0; pa = '0; got_done = 1'b0; exp_sum = '0;
        for (int c = 0; c < 200 && !got_done; c++) begin
            out_ready = ((c % 4) == 0) || ((c % 4) == 3);
            if (out_valid && pv && !pr) begin
                checks++;
                if (out_data !== pd || out_addr !== pa) begin
                    errors++; $display("FAIL stall_hold: addr %0d data %h want %0d %h", out_addr, out_data, pa, pd);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (out_addr !== AW'(exp_idx) || out_data !== pat(3, exp_idx) || out_last !== (exp_idx == NR - 1)) begin
                    errors++;
                    $display("FAIL stall_beat %0d: addr %0d data %h last %b want %0d %h %b",
                             exp_idx, out_addr, out_data, out_last, exp_idx, pat(3, exp_idx), exp_idx == NR - 1);
                end
                exp_sum = exp_sum ^ pat(3, exp_idx);
                exp_idx++;
            end
            if (done) got_done = 1'b1;
            pv = out_valid; pr = out_ready; pd = out_data; pa = out_addr;
            if (!got_done) tick();
        end
        checks++;
        if (got_done !== 1'b1 || exp_idx != NR || busy !== 1'b0) begin
            errors++; $display("FAIL stall_complete: done %b beats %0d busy %b want 1 %0d 0", got_done, exp_idx, busy, NR);
        end
`ifndef REGFILE_SWEEP_CHECKSUM_EN
        exp_sum = '0;
`endif
        checks++;
        if (checksum !== exp_sum) begin
            errors++; $display("FAIL stall_checksum: got %h want %h", checksum, exp_sum);
        end
    endtask

    task automatic test_clear();
        int   wcount, done_at;
        logic bad;
        preload(0);
        out_ready = 1'b1; start = 1'b1; mode = 1'b1;
        wcount = 0; done_at = -1;
        for (int c = 1; c <= 60 && done_at < 0; c++) begin
            tick();
            start = 1'b0;
            if (rf_write_en) begin
                checks++;
                if (rf_write_addr !== AW'(wcount) || rf_write_data !== '0 || busy !== 1'b1) begin
                    errors++; $display("FAIL clear_write %0d: addr %0d data %h busy %b want %0d 0 1", wcount, rf_write_addr, rf_write_data, busy, wcount);
                end
                wcount++;
            end
            if (done) done_at = c;
        end
        checks++;
        if (wcount != NR || done_at != NR + 1) begin
            errors++; $display("FAIL clear_count: writes %0d done_at %0d want %0d %0d", wcount, done_at, NR, NR + 1);
        end
        start = 1'b1; mode = 1'b0;
        tick();
        start = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < NR; k++) begin
            tick();
            if (out_valid !== 1'b1 || out_addr !== AW'(k) || out_data !== '0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++; $display("FAIL clear_then_dump: nonzero or misordered beat seen, flag %b want 0", bad);
        end
        tick();
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL clear_then_dump_done: got %b want 1", done);
        end
    endtask

    task automatic test_start_ignored();
        int done_at;
        preload(0);
        out_ready = 1'b1; start = 1'b1; mode = 1'b0;
        tick();
        start = 1'b0;
        for (int c = 2; c <= 34; c++) begin
            tick();
            start = (c == 5) || (c == 20);
            mode  = (c == 5);
            if (c <= 33) begin
                checks++;
                if (out_valid !== 1'b1 || out_addr !== AW'(c - 2) || out_data !== 64'h1000 + DW'(c - 2) || rf_write_en !== 1'b0) begin
                    errors++; $display("FAIL ignore_beat c%0d: valid %b addr %0d data %h wen %b want 1 %0d %h 0",
                                       c, out_valid, out_addr, out_data, rf_write_en, c - 2, 64'h1000 + DW'(c - 2));
                end
            end
        end
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL ignore_done: got %b want 1", done);
        end
        start = 1'b1; mode = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || rf_write_en !== 1'b1 || rf_write_addr !== '0) begin
            errors++; $display("FAIL start_in_done: busy %b wen %b addr %0d want 1 1 0", busy, rf_write_en, rf_write_addr);
        end
        done_at = -1;
        for (int c = 2; c <= 40 && done_at < 0; c++) begin
            tick();
            if (done) done_at = c;
        end
        checks++;
        if (done_at != NR + 1) begin
            errors++; $display("FAIL chained_clear_done: got %0d want %0d", done_at, NR + 1);
        end
    endtask

    task automatic test_reset_abort();
        logic bad;
        preload(0);
        out_ready = 1'b1; start = 1'b1; mode = 1'b0;
        tick();
        start = 1'b0;
        for (int c = 2; c <= 12; c++) tick();
        checks++;
        if (out_addr !== AW'(10)) begin
            errors++; $display("FAIL abort_dump_pos: addr %0d want 10", out_addr);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_addr !== '0 || out_data !== '0) begin
            errors++; $display("FAIL abort_dump_async: valid %b busy %b addr %0d data %h want 0 0 0 0", out_valid, busy, out_addr, out_data);
        end
        tick(); tick();
        reset = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++; $display("FAIL abort_dump_quiet: activity after abort flag %b want 0", bad);
        end

        preload(0);
        start = 1'b1; mode = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 2; c <= 11; c++) tick();
        checks++;
        if (rf_write_en !== 1'b1 || rf_write_addr !== AW'(10)) begin
            errors++; $display("FAIL abort_clear_pos: wen %b addr %0d want 1 10", rf_write_en, rf_write_addr);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (rf_write_en !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_clear_async: wen %b busy %b want 0 0", rf_write_en, busy);
        end
        tick();
        reset = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (done !== 1'b0 || rf_write_en !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++; $display("FAIL abort_clear_quiet: activity after abort flag %b want 0", bad);
        end
        for (int i = 0; i < NR; i++) begin
            checks++;
            if (rf[i] !== ((i < 10) ? 64'h0 : 64'h1000 + DW'(i))) begin
                errors++; $display("FAIL abort_clear_rf[%0d]: got %h want %h", i, rf[i], (i < 10) ? 64'h0 : 64'h1000 + DW'(i));
            end
        end
    endtask

    task automatic test_checksum();
        int            cyc;
        logic [DW-1:0] exp_a, exp_b;
`ifdef REGFILE_SWEEP_CHECKSUM_EN
        exp_a = '0;
        for (int i = 0; i < NR; i++) exp_a = exp_a ^ pat(1, i);
        exp_b = 64'hFF;
`else
        exp_a = '0;
        exp_b = '0;
`endif
        preload(1);
        run_cmd(1'b0, cyc);
        checks++;
        if (cyc != NR + 2 || checksum !== exp_a) begin
            errors++; $display("FAIL checksum_idx: done_at %0d sum %h want %0d %h", cyc, checksum, NR + 2, exp_a);
        end
        preload(2);
        run_cmd(1'b0, cyc);
        tick(); tick();
        checks++;
        if (checksum !== exp_b) begin
            errors++; $display("FAIL checksum_ff_hold: got %h want %h", checksum, exp_b);
        end
        run_cmd(1'b1, cyc);
        checks++;
        if (cyc != NR + 1 || checksum !== exp_b) begin
            errors++; $display("FAIL checksum_after_clear: done_at %0d sum %h want %0d %h", cyc, checksum, NR + 1, exp_b);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_dump_full();
        test_dump_stall();
        test_clear();
        test_start_ignored();
        test_reset_abort();
        test_checksum();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
